gpsreceiver2_capture: RTL and testbench

Front-end sample capture engine for the GPS receiver: packs 2-bit sign/magnitude samples from the RF front-end into bytes and drives the byte-wide write port (`rxb0_dat`/`rxb0_adr`/`rxb0_we`) of the receive sample buffer. It lives entirely in the `gps_rec_clk` domain. It supports one-shot captures of a programmable length and continuous ring-buffer capture. Control inputs are already synchronized into `gps_rec_clk` by the caller.

---
 rtl/gpsreceiver2_capture.sv | 123 ++++++++++++
 tb/tb_gpsreceiver2_capture.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpsreceiver2_capture.sv
// Purpose: packs 2-bit sign/magnitude GPS samples into bytes and writes them to the receive sample buffer (one-shot or ring capture).
// Latency: a byte write is issued one cycle after the sample_en that completes it; busy/done change one cycle after start/stop.
// Backpressure: none, the buffer write port always accepts; samples outside CAPTURE are dropped.
// Option: define GPSRECEIVER2_CAPTURE_SIGNONLY_EN for 1-bit sign-only samples, eight per byte.
module gpsreceiver2_capture #(
   parameter int DEPTH_LOG2 = 11
) (
   input  logic                  gps_rec_clk,
   input  logic                  sys_rst,
   input  logic                  sample_en,
   input  logic                  gps_sign,
   input  logic                  gps_mag,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  continuous,
   input  logic [DEPTH_LOG2-1:0] len_m1,
   output logic [7:0]            rxb0_dat,
   output logic [DEPTH_LOG2-1:0] rxb0_adr,
   output logic                  rxb0_we,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           wrap_cnt
);

`ifdef GPSRECEIVER2_CAPTURE_SIGNONLY_EN
   localparam int SMP_W  = 1;
   localparam int SLOT_W = 3;
`else
   localparam int SMP_W  = 2;
   localparam int SLOT_W = 2;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t                  state;
   logic [SLOT_W-1:0]       slot;
   logic [7:0]              pack;
   logic [DEPTH_LOG2-1:0]   len_q;
   logic                    cont_q;

   logic [SMP_W-1:0]        smp;
   logic [7:0]              byte_nxt;
   logic                    commit;
   logic                    last_adr;

`ifdef GPSRECEIVER2_CAPTURE_SIGNONLY_EN
   assign smp = gps_sign;
`else
   assign smp = {gps_sign, gps_mag};
`endif

   // Shift the new sample in from the top: after a full byte the oldest sample sits in the LSBs.
   always_comb begin
      byte_nxt = {smp, pack[7:SMP_W]};
   end

   assign commit   = (state == S_CAPTURE) && sample_en && (&slot);
   assign last_adr = (rxb0_adr == len_q);

   // Capture state machine with registered buffer-write and status outputs.
   always_ff @(posedge gps_rec_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state    <= S_IDLE;
         slot     <= '0;
         pack     <= '0;
         len_q    <= '0;
         cont_q   <= 1'b0;
         rxb0_dat <= '0;
         rxb0_adr <= '0;
         rxb0_we  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         wrap_cnt <= '0;
      end else begin
         rxb0_we <= 1'b0;

         // The address advances the cycle after each write; a ring wrap is counted when it rolls over.
         if (rxb0_we) begin
            rxb0_adr <= rxb0_adr + DEPTH_LOG2'(1);
            if (cont_q && (&rxb0_adr) && (wrap_cnt != 16'hFFFF))
               wrap_cnt <= wrap_cnt + 16'd1;
         end

         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state    <= S_CAPTURE;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  len_q    <= len_m1;
                  cont_q   <= continuous;
                  rxb0_adr <= '0;
                  slot     <= '0;
                  wrap_cnt <= '0;
               end
            end
            S_CAPTURE: begin
               if (sample_en) begin
                  pack <= byte_nxt;
                  slot <= slot + SLOT_W'(1);
               end
               if (commit) begin
                  rxb0_we  <= 1'b1;
                  rxb0_dat <= byte_nxt;
               end
               // Stop discards any partial byte; a byte completed on the same cycle is still written.
               if (stop || (commit && !cont_q && last_adr)) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  slot  <= '0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpsreceiver2_capture.sv
// Testbench for gpsreceiver2_capture: directed captures with a write scoreboard.
// Each expected buffer write (address, data, busy, done) is queued by the stimulus;
// a negedge monitor pops and compares on every rxb0_we.
module tb_gpsreceiver2_capture;

   logic        gps_rec_clk;
   logic        sys_rst;
   logic        sample_en;
   logic        gps_sign;
   logic        gps_mag;
   logic        start;
   logic        stop;
   logic        continuous;
   logic [10:0] len_m1;
   logic [7:0]  rxb0_dat;
   logic [10:0] rxb0_adr;
   logic        rxb0_we;
   logic        busy;
   logic        done;
   logic [15:0] wrap_cnt;

   typedef struct {
      logic [10:0] adr;
      logic [7:0]  dat;
      logic        busy;
      logic        done;
   } wr_t;

   wr_t q[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   gpsreceiver2_capture #(.DEPTH_LOG2(11)) dut (
      .gps_rec_clk (gps_rec_clk),
      .sys_rst     (sys_rst),
      .sample_en   (sample_en),
      .gps_sign    (gps_sign),
      .gps_mag     (gps_mag),
      .start       (start),
      .stop        (stop),
      .continuous  (continuous),
      .len_m1      (len_m1),
      .rxb0_dat    (rxb0_dat),
      .rxb0_adr    (rxb0_adr),
      .rxb0_we     (rxb0_we),
      .busy        (busy),
      .done        (done),
      .wrap_cnt    (wrap_cnt)
   );

   initial gps_rec_clk = 1'b0;
   always #5 gps_rec_clk = ~gps_rec_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every buffer write must match the next queued expectation.
   always @(negedge gps_rec_clk) begin
      if (rxb0_we === 1'b1) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: adr=%0d dat=0x%0h, expected no write (t=%0t)", rxb0_adr, rxb0_dat, $time);
         end else begin
            wr_t e;
            e = q.pop_front();
            chk("wr_adr",  32'(rxb0_adr), 32'(e.adr));
            chk("wr_dat",  32'(rxb0_dat), 32'(e.dat));
            chk("wr_busy", 32'(busy),     32'(e.busy));
            chk("wr_done", 32'(done),     32'(e.done));
         end
      end
   end

   task automatic tick();
      @(posedge gps_rec_clk);
      #1;
   endtask

   task automatic do_start(input logic [10:0] l, input logic c);
      start      = 1'b1;
      len_m1     = l;
      continuous = c;
      tick();
      start      = 1'b0;
   endtask

   task automatic smp(input logic s, input logic m, input logic stp);
      sample_en = 1'b1;
      gps_sign  = s;
      gps_mag   = m;
      stop      = stp;
      tick();
      sample_en = 1'b0;
      stop      = 1'b0;
   endtask

   // Sample k of a byte occupies bits [2k+1:2k] = {sign, mag}.
   task automatic feed_byte(input logic [7:0] b);
      for (int k = 0; k < 4; k++)
         smp(b[2*k+1], b[2*k], 1'b0);
   endtask

   task automatic expect_wr(input logic [10:0] a, input logic [7:0] d, input logic bz, input logic dn);
      wr_t e;
      e.adr  = a;
      e.dat  = d;
      e.busy = bz;
      e.done = dn;
      q.push_back(e);
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   initial begin
      sys_rst    = 1'b1;
      sample_en  = 1'b0;
      gps_sign   = 1'b0;
      gps_mag    = 1'b0;
      start      = 1'b0;
      stop       = 1'b0;
      continuous = 1'b0;
      len_m1     = '0;
      repeat (2) tick();
      sys_rst = 1'b0;
      tick();

      // Reset state
      chk("rst_we",   32'(rxb0_we),  32'd0);
      chk("rst_dat",  32'(rxb0_dat), 32'd0);
      chk("rst_adr",  32'(rxb0_adr), 32'd0);
      chk("rst_busy", 32'(busy),     32'd0);
      chk("rst_done", 32'(done),     32'd0);
      chk("rst_wrap", 32'(wrap_cnt), 32'd0);

      // One-shot, 4 bytes. Samples (1,0),(0,1),(1,1),(0,0) into slots 0..3:
      // byte = {00,11,01,10} = 8'h36.
      do_start(11'd3, 1'b0);
      chk("os_busy_rise", 32'(busy), 32'd1);
      expect_wr(11'd0, 8'h36, 1'b1, 1'b0);
      expect_wr(11'd1, 8'h36, 1'b1, 1'b0);
      expect_wr(11'd2, 8'h36, 1'b1, 1'b0);
      expect_wr(11'd3, 8'h36, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         smp(1'b1, 1'b0, 1'b0);
         smp(1'b0, 1'b1, 1'b0);
         smp(1'b1, 1'b1, 1'b0);
         smp(1'b0, 1'b0, 1'b0);
      end
      repeat (2) tick();
      chk("os_done", 32'(done),     32'd1);
      chk("os_busy", 32'(busy),     32'd0);
      chk("os_adr",  32'(rxb0_adr), 32'd4);

      // Samples in DONE are ignored (no write expected); stop in DONE is ignored.
      feed_byte(8'hFF);
      pulse_stop();
      tick();
      chk("done_hold", 32'(done),     32'd1);
      chk("adr_hold",  32'(rxb0_adr), 32'd4);

      // Start in DONE restarts at address 0; start during CAPTURE is ignored.
      do_start(11'd1, 1'b0);
      chk("restart_done", 32'(done),     32'd0);
      chk("restart_busy", 32'(busy),     32'd1);
      chk("restart_adr",  32'(rxb0_adr), 32'd0);
      expect_wr(11'd0, 8'hA5, 1'b1, 1'b0);
      feed_byte(8'hA5);
      do_start(11'd0, 1'b1);
      expect_wr(11'd1, 8'h3C, 1'b0, 1'b1);
      feed_byte(8'h3C);
      repeat (2) tick();
      chk("ign_start_done", 32'(done), 32'd1);

      // Stop after 6 samples: one write, partial byte dropped.
      do_start(11'd10, 1'b0);
      expect_wr(11'd0, 8'h1B, 1'b1, 1'b0);
      feed_byte(8'h1B);
      smp(1'b1, 1'b1, 1'b0);
      smp(1'b0, 1'b1, 1'b0);
      pulse_stop();
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_done", 32'(done), 32'd1);
      repeat (3) tick();
      chk("stop_adr", 32'(rxb0_adr), 32'd1);

      // Stop coincident with the 4th sample: byte still written, DONE with it.
      do_start(11'd10, 1'b0);
      expect_wr(11'd0, 8'hE4, 1'b0, 1'b1);
      smp(1'b0, 1'b0, 1'b0);
      smp(1'b0, 1'b1, 1'b0);
      smp(1'b1, 1'b0, 1'b0);
      smp(1'b1, 1'b1, 1'b1);
      repeat (2) tick();
      chk("stopc_done", 32'(done),     32'd1);
      chk("stopc_adr",  32'(rxb0_adr), 32'd1);

      // Continuous: 2049 bytes wrap the ring once.
      do_start(11'd0, 1'b1);
      for (int i = 0; i < 2049; i++) begin
         logic [7:0] b;
         b = i[7:0] ^ 8'h5A;
         expect_wr(11'(i % 2048), b, 1'b1, 1'b0);
         feed_byte(b);
      end
      repeat (2) tick();
      chk("ring_wrap", 32'(wrap_cnt), 32'd1);
      chk("ring_busy", 32'(busy),     32'd1);
      chk("ring_done", 32'(done),     32'd0);
      chk("ring_adr",  32'(rxb0_adr), 32'd1);
      pulse_stop();
      chk("ring_stop_busy", 32'(busy), 32'd0);
      tick();

      // Asynchronous reset mid-byte.
      do_start(11'd5, 1'b0);
      expect_wr(11'd0, 8'hC3, 1'b1, 1'b0);
      feed_byte(8'hC3);
      smp(1'b1, 1'b0, 1'b0);
      smp(1'b0, 1'b1, 1'b0);
      #2;
      sys_rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy),     32'd0);
      chk("arst_adr",  32'(rxb0_adr), 32'd0);
      chk("arst_dat",  32'(rxb0_dat), 32'd0);
      chk("arst_we",   32'(rxb0_we),  32'd0);
      chk("arst_done", 32'(done),     32'd0);
      tick();
      sys_rst = 1'b0;
      tick();
      do_start(11'd5, 1'b0);
      expect_wr(11'd0, 8'h96, 1'b1, 1'b0);
      feed_byte(8'h96);
      repeat (3) tick();
      pulse_stop();
      repeat (3) tick();

      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
